// File: rtl/adc_scan_sequencer_pkg.sv
// adc_scan_pkg: shared FSM encoding, channel field width and default parameters
package adc_scan_pkg;
  localparam int CH_W        = 5;
  localparam int DEF_NUM_CH  = 3;
  localparam int DEF_DATA_W  = 12;
  localparam int DEF_PERSIST = 4;
  localparam int DEF_TIMEOUT = 255;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EVAL} state_t;
endpackage

// File: rtl/adc_scan_sequencer_if.sv
// adc_scan_sequencer_if: conversion request/response handshake between sequencer and ADC core
interface adc_scan_sequencer_if import adc_scan_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
  logic              cmd_valid;
  logic [CH_W-1:0]   cmd_channel;
  logic              cmd_ready;
  logic              rsp_valid;
  logic [CH_W-1:0]   rsp_channel;
  logic [DATA_W-1:0] rsp_data;
  modport master (output cmd_valid, cmd_channel, input cmd_ready, rsp_valid, rsp_channel, rsp_data);
  modport slave  (input cmd_valid, cmd_channel, output cmd_ready, rsp_valid, rsp_channel, rsp_data);
endinterface

// File: rtl/adc_scan_sequencer_persist_cell.sv
// adc_persist_cell: per-channel threshold compare, saturating persistence counter and sticky fault
module adc_persist_cell import adc_scan_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PERSIST = DEF_PERSIST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_eval,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_thr,
  output logic              o_fault
);
  logic [3:0] r_cnt;
  logic       r_fault;
  logic       w_over;
  logic [3:0] w_cnt_nxt;
  logic       w_set;
  // next counter value for an evaluated sample; strict unsigned compare
  always_comb begin
    w_over    = i_data > i_thr;
    w_cnt_nxt = !w_over ? 4'd0 : r_cnt == 4'(PERSIST) ? r_cnt : r_cnt + 4'd1;
    w_set     = i_eval && w_cnt_nxt == 4'(PERSIST);
  end
  // evaluation and fault set win over a coincident clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_cnt   <= i_eval ? w_cnt_nxt : i_clr ? 4'd0 : r_cnt;
      r_fault <= w_set | (r_fault & ~i_clr);
    end
  end
  assign o_fault = r_fault;
endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: round-robin ADC channel scanner with persistence-filtered over-threshold faults
module adc_scan_sequencer import adc_scan_pkg::*; #(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PERSIST = DEF_PERSIST,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_enable,
  adc_scan_sequencer_if.master     bus,
  input  logic [NUM_CH*DATA_W-1:0] i_thr_hi,
  input  logic                     i_fault_clr,
  output logic [NUM_CH-1:0]        o_fault,
  output logic                     o_fault_any,
  output logic                     o_timeout_err,
  output logic [NUM_CH*DATA_W-1:0] o_sample
);
  state_t            r_state;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   r_cmd_channel;
  logic [9:0]        r_timer;
  logic [DATA_W-1:0] r_data;
  logic              r_cmd_valid;
  logic              r_timeout_err;
  logic [CH_W-1:0]   w_ch_nxt;
  logic              w_match;
  logic              w_timeout;
  logic              w_adv;
  // channel wrap, response match and end-of-transaction detection
  always_comb begin
    w_ch_nxt  = r_ch == CH_W'(NUM_CH - 1) ? '0 : r_ch + CH_W'(1);
    w_match   = bus.rsp_valid && bus.rsp_channel == r_ch;
    w_timeout = r_state == WAIT && !w_match && r_timer == 10'(TIMEOUT - 1);
    w_adv     = w_timeout || r_state == EVAL;
  end
  // scan FSM with registered command outputs; a transaction always finishes before IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_ch          <= '0;
      r_timer       <= '0;
      r_data        <= '0;
      r_cmd_valid   <= 1'b0;
      r_cmd_channel <= '0;
    end else if (w_adv) begin
      r_ch          <= w_ch_nxt;
      r_state       <= i_enable ? ISSUE : IDLE;
      r_cmd_valid   <= i_enable;
      r_cmd_channel <= w_ch_nxt;
    end else begin
      case (r_state)
        IDLE: if (i_enable) begin
          r_state       <= ISSUE;
          r_cmd_valid   <= 1'b1;
          r_cmd_channel <= r_ch;
        end
        ISSUE: if (bus.cmd_ready) begin
          r_state     <= WAIT;
          r_cmd_valid <= 1'b0;
          r_timer     <= '0;
        end
        WAIT: if (w_match) begin
          r_state <= EVAL;
          r_data  <= bus.rsp_data;
        end else r_timer <= r_timer + 10'd1;
        EVAL: ;
      endcase
    end
  end
  // sticky missed-response flag; a new timeout wins over a coincident clear
  always_ff @(posedge clk) begin
    if (reset) r_timeout_err <= 1'b0;
    else r_timeout_err <= w_timeout | (r_timeout_err & ~i_fault_clr);
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic              w_eval;
    logic [DATA_W-1:0] r_sample;
    assign w_eval = r_state == EVAL && r_ch == CH_W'(k);
    adc_persist_cell #(.DATA_W(DATA_W), .PERSIST(PERSIST)) u_cell (
      .clk     (clk),
      .reset   (reset),
      .i_eval  (w_eval),
      .i_clr   (i_fault_clr),
      .i_data  (r_data),
      .i_thr   (i_thr_hi[k*DATA_W +: DATA_W]),
      .o_fault (o_fault[k])
    );
    // last accepted sample for this channel
    always_ff @(posedge clk) begin
      if (reset) r_sample <= '0;
      else if (w_eval) r_sample <= r_data;
    end
    assign o_sample[k*DATA_W +: DATA_W] = r_sample;
  end
  assign bus.cmd_valid   = r_cmd_valid;
  assign bus.cmd_channel = r_cmd_channel;
  assign o_fault_any     = |o_fault;
  assign o_timeout_err   = r_timeout_err;
endmodule
